puf_response_collector: RTL and testbench
=========================================

Name: puf_response_collector

Overview:
- Clocked control stage directly downstream of the RO edge-counter block.
- Drives the counter's challenge pair (cha0/cha1), its active-low clear, and a ring-oscillator enable.
- Runs one measurement window per response bit, then samples the counter's Response bit and both 4-bit counts through synchronisers.
- Assembles NUM_BITS response bits plus a per-bit tie ("unstable") mask, and hands them off with valid/ready.

Parameters:
- NUM_BITS, 8, response bits collected per start.
- WINDOW_CYCLES, 64, clk cycles ro_en is held high per bit (>=1).
- CLR_CYCLES, 2, clk cycles cnt_rst_n is held low before each window (>=1).
- SYNC_CYCLES, 3, wait after ro_en falls before sampling (>=2, covers the 2-flop synchroniser).

Ports:
- clk, input, 1, system clock.
- reset, input, 1, asynchronous active-low reset.
- start, input, 1, one-cycle request; accepted only in IDLE.
- seed, input, 8, {first cha0, first cha1} for bit 0.
- cha0, output, 4, challenge index A to the counter.
- cha1, output, 4, challenge index B to the counter.
- cnt_rst_n, output, 1, active-low clear to the counter.
- ro_en, output, 1, oscillator enable / counting gate.
- puf_bit, input, 1, counter Response (async domain).
- cnt_a, input, 4, counter out1 (async domain).
- cnt_b, input, 4, counter out2 (async domain).
- busy, output, 1, high from start acceptance until DONE is entered.
- resp_valid, output, 1, response available.
- resp_ready, input, 1, consumer accept.
- response, output, NUM_BITS, collected bits; bit i comes from pair i.
- unstable, output, NUM_BITS, bit i set when cnt_a==cnt_b at the bit-i sample.

Behaviour:
- Reset (reset low, async): state=IDLE, cha0=cha1=0, cnt_rst_n=0, ro_en=0, busy=0, resp_valid=0, response=0, unstable=0, bit index=0, timer=0, synchronisers=0.
- Synchronisers: 2-flop synchroniser on puf_bit, cnt_a and cnt_b. Counts are quasi-static when sampled because ro_en is low.
- IDLE:
  - cnt_rst_n=0 and ro_en=0.
  - When start=1: load cha0=seed[7:4], cha1=seed[3:0]. If they are equal, use cha1=seed[3:0]+1 mod 16.
  - Clear response, unstable and the bit index; set busy=1; go to CLEAR.
- CLEAR: cnt_rst_n=0, ro_en=0 for exactly CLR_CYCLES cycles, then go to MEASURE.
- MEASURE: cnt_rst_n=1, ro_en=1 for exactly WINDOW_CYCLES cycles, then go to SETTLE.
- SETTLE: ro_en=0, cnt_rst_n=1 for SYNC_CYCLES cycles, then go to CAPTURE.
- CAPTURE (1 cycle):
  - response[idx] <= synced puf_bit.
  - unstable[idx] <= (synced cnt_a == synced cnt_b).
  - If idx==NUM_BITS-1, go to DONE.
  - Otherwise idx++, then cha0 <= cha0+1 and cha1 <= cha1+3, both mod 16. If the new values collide, cha1 gets a further +1. Go to CLEAR.
- DONE:
  - busy=0, resp_valid=1. response and unstable stay stable while valid.
  - When resp_valid && resp_ready: resp_valid=0 in the next cycle and state goes to IDLE. response and unstable keep their values until the next start.
- start while not IDLE: ignored, no effect.
- start and resp_ready in the same cycle in DONE: the handshake completes, start is ignored, and start must be re-pulsed.
- Per-bit latency is CLR_CYCLES+WINDOW_CYCLES+SYNC_CYCLES+1 cycles; the default is 70.
- Total latency is NUM_BITS times the per-bit latency; the default is 560 cycles from start to resp_valid.
- Reset asserted mid-operation:
  - Immediate return to reset values, including ro_en=0.
  - A partial response is discarded and is never presented valid.
- Challenge wrap: cha arithmetic is 4-bit modulo. The pair cha0 == cha1 is never driven while ro_en=1.
- Counts wrapping inside the counter are not detected here. Equality of the sampled counts is the only instability criterion.

Decomposition:
- Shared package puf_pkg:
  - state encoding (IDLE, CLEAR, MEASURE, SETTLE, CAPTURE, DONE);
  - CHAL_W=4 and CNT_W=4;
  - challenge step constants (A step 1, B step 3, collision bump 1).
- One sub-module, puf_sync2: a parameterised-width 2-flop synchroniser with async active-low reset.
  - Instantiated once, 9 bits wide, for {puf_bit, cnt_a, cnt_b}.

Test Plan:
- Reset mid-window:
  - Stimulus: start with seed=8'hC8, then pull reset low at cycle 30.
  - Required: ro_en=0, cnt_rst_n=0, busy=0 and resp_valid=0 immediately (async). No valid ever follows.
- Default run:
  - Stimulus: seed=8'hC8, puf_bit model=1 for even bits and 0 for odd bits, cnt_a=9, cnt_b=5.
  - Required: resp_valid at cycle 560; response=8'h55; unstable=8'h00.
  - Required: bit 0 uses cha pair (C,8); bit 1 uses (D,B).
- Collision:
  - Stimulus: seed=8'h33.
  - Required: bit 0 pair=(3,4).
  - Required: bit 1 pair=(4,7). cha0 never equals cha1 in any MEASURE cycle.
- Tie detection:
  - Stimulus: cnt_a=cnt_b=7 during bit 2 only.
  - Required: unstable=8'h04.
- Backpressure:
  - Stimulus: hold resp_ready=0 for 20 cycles after resp_valid, pulse start during that time, then raise resp_ready.
  - Required: response stable throughout; start ignored; resp_valid drops one cycle after the handshake; state returns to IDLE.
- Timing check:
  - Stimulus: WINDOW_CYCLES=10, CLR_CYCLES=2.
  - Required: ro_en high for exactly 10 cycles per bit; cnt_rst_n low for exactly 2 cycles before each window.

Source files
------------

// File: rtl/puf_pkg.sv
// Shared definitions for the PUF response collector.
//   state_t      : collector FSM encoding
//   CHAL_W/CNT_W : challenge index and edge-count widths
//   STEP_*/BUMP  : per-bit challenge walk and collision bump
//   dodge()      : returns b, bumped when it would equal a
package puf_pkg;

  localparam int CHAL_W = 4;
  localparam int CNT_W  = 4;

  localparam logic [CHAL_W-1:0] STEP_A = 4'd1;
  localparam logic [CHAL_W-1:0] STEP_B = 4'd3;
  localparam logic [CHAL_W-1:0] BUMP   = 4'd1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_MEASURE,
    S_SETTLE,
    S_CAPTURE,
    S_DONE
  } state_t;

  // Comparing an oscillator against itself gives no information, so a
  // colliding B index is pushed one step further.
  function automatic logic [CHAL_W-1:0] dodge(input logic [CHAL_W-1:0] a,
                                              input logic [CHAL_W-1:0] b);
    return (a == b) ? b + BUMP : b;
  endfunction

endpackage

// File: rtl/puf_sync2.sv
// Parameterised-width two-flop synchroniser.
//   clk   : destination clock
//   rst_n : async active-low reset, clears both stages
//   d     : asynchronous input bus
//   q     : synchronised output (two clk cycles of latency)
module puf_sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/puf_response_collector.sv
// Control stage for a ring-oscillator edge-counter PUF.
// For each response bit: clear the counter, gate the oscillators for a
// fixed window, let the counts settle through the synchroniser, then
// capture the response bit and a tie flag. Challenges walk A+1 / B+3.
//   clk, reset          : clock, async active-low reset
//   start, seed         : one-cycle request and {cha0, cha1} for bit 0
//   cha0, cha1          : challenge pair to the counter
//   cnt_rst_n, ro_en    : counter clear (active low) and count gate
//   puf_bit, cnt_a/b    : counter results (asynchronous domain)
//   busy                : collection in progress
//   resp_valid/ready    : response handshake
//   response, unstable  : collected bits and per-bit tie mask
module puf_response_collector
  import puf_pkg::*;
#(
  parameter int NUM_BITS      = 8,
  parameter int WINDOW_CYCLES = 64,
  parameter int CLR_CYCLES    = 2,
  parameter int SYNC_CYCLES   = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [2*CHAL_W-1:0] seed,
  output logic [CHAL_W-1:0]   cha0,
  output logic [CHAL_W-1:0]   cha1,
  output logic                cnt_rst_n,
  output logic                ro_en,
  input  logic                puf_bit,
  input  logic [CNT_W-1:0]    cnt_a,
  input  logic [CNT_W-1:0]    cnt_b,
  output logic                busy,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [NUM_BITS-1:0] response,
  output logic [NUM_BITS-1:0] unstable
);

  localparam int T01   = (WINDOW_CYCLES > CLR_CYCLES) ? WINDOW_CYCLES : CLR_CYCLES;
  localparam int TMAX  = (T01 > SYNC_CYCLES) ? T01 : SYNC_CYCLES;
  localparam int TMR_W = $clog2(TMAX + 1);
  localparam int IDX_W = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;

  state_t             state, state_nxt;
  logic [TMR_W-1:0]   timer;
  logic [IDX_W-1:0]   idx;
  logic               last;
  logic [2*CNT_W:0]   sync_q;
  logic               s_puf;
  logic [CNT_W-1:0]   s_a, s_b;
  logic [CHAL_W-1:0]  nxt_a, nxt_b;

  puf_sync2 #(.W(2*CNT_W+1)) u_sync (
    .clk   (clk),
    .rst_n (reset),
    .d     ({puf_bit, cnt_a, cnt_b}),
    .q     (sync_q)
  );

  assign s_puf = sync_q[2*CNT_W];
  assign s_a   = sync_q[2*CNT_W-1:CNT_W];
  assign s_b   = sync_q[CNT_W-1:0];

  assign last  = (idx == IDX_W'(NUM_BITS - 1));
  assign nxt_a = cha0 + STEP_A;
  assign nxt_b = dodge(nxt_a, cha1 + STEP_B);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start) state_nxt = S_CLEAR;
      S_CLEAR:   if (timer == TMR_W'(CLR_CYCLES - 1))    state_nxt = S_MEASURE;
      S_MEASURE: if (timer == TMR_W'(WINDOW_CYCLES - 1)) state_nxt = S_SETTLE;
      S_SETTLE:  if (timer == TMR_W'(SYNC_CYCLES - 1))   state_nxt = S_CAPTURE;
      S_CAPTURE: state_nxt = last ? S_DONE : S_CLEAR;
      S_DONE:    if (resp_ready) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so the analog-facing
  // controls are glitch-free yet still track the state exactly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ro_en      <= 1'b0;
      cnt_rst_n  <= 1'b0;
      busy       <= 1'b0;
      resp_valid <= 1'b0;
    end else begin
      ro_en      <= (state_nxt == S_MEASURE);
      cnt_rst_n  <= (state_nxt == S_MEASURE) || (state_nxt == S_SETTLE) ||
                    (state_nxt == S_CAPTURE);
      busy       <= (state_nxt != S_IDLE) && (state_nxt != S_DONE);
      resp_valid <= (state_nxt == S_DONE);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer    <= '0;
      idx      <= '0;
      cha0     <= '0;
      cha1     <= '0;
      response <= '0;
      unstable <= '0;
    end else begin
      // Timer counts cycles spent in the current timed state.
      if (state_nxt != state)
        timer <= '0;
      else if (state == S_CLEAR || state == S_MEASURE || state == S_SETTLE)
        timer <= timer + 1'b1;

      case (state)
        S_IDLE: if (start) begin
          cha0     <= seed[2*CHAL_W-1:CHAL_W];
          cha1     <= dodge(seed[2*CHAL_W-1:CHAL_W], seed[CHAL_W-1:0]);
          response <= '0;
          unstable <= '0;
          idx      <= '0;
        end
        S_CAPTURE: begin
          response[idx] <= s_puf;
          unstable[idx] <= (s_a == s_b);
          if (!last) begin
            idx  <= idx + 1'b1;
            cha0 <= nxt_a;
            cha1 <= nxt_b;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_puf_response_collector.sv
// Directed bench for puf_response_collector. A negedge monitor plays the
// edge counter (drives puf_bit/counts per window from pat/tie), logs the
// challenge pair of each window and pops expected responses from a
// scoreboard queue on every handshake. A second instance with a short
// window checks the ro_en / cnt_rst_n pulse widths.
module tb_puf_response_collector;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start, resp_ready;
  logic [7:0] seed;
  logic       puf_drv = 1'b0;
  logic [3:0] a_drv = 4'd9, b_drv = 4'd5;
  logic [3:0] cha0, cha1;
  logic       cnt_rst_n, ro_en, busy, resp_valid;
  logic [7:0] response, unstable;

  logic       start_t, puf_t, ready_t;
  logic [3:0] a_t, b_t, cha0_t, cha1_t;
  logic       crn_t, ro_t, busy_t, valid_t;
  logic [7:0] resp_t, unst_t;

  puf_response_collector dut (
    .clk(clk), .reset(reset), .start(start), .seed(seed),
    .cha0(cha0), .cha1(cha1), .cnt_rst_n(cnt_rst_n), .ro_en(ro_en),
    .puf_bit(puf_drv), .cnt_a(a_drv), .cnt_b(b_drv),
    .busy(busy), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .response(response), .unstable(unstable)
  );

  puf_response_collector #(.WINDOW_CYCLES(10), .CLR_CYCLES(2)) dut_t (
    .clk(clk), .reset(reset), .start(start_t), .seed(8'hC8),
    .cha0(cha0_t), .cha1(cha1_t), .cnt_rst_n(crn_t), .ro_en(ro_t),
    .puf_bit(puf_t), .cnt_a(a_t), .cnt_b(b_t),
    .busy(busy_t), .resp_valid(valid_t), .resp_ready(ready_t),
    .response(resp_t), .unstable(unst_t)
  );

  int checks = 0, errors = 0;
  int cyc = 0, start_cyc = 0, vrises = 0, hs = 0, hs_t = 0, mcount = 0;
  int lowcnt = 0, hicnt = 0, wins = 0;
  logic [7:0]  pat = 8'h00, tie = 8'h00;
  logic [7:0]  pair_log [8];
  logic [15:0] expq [$];
  logic [15:0] e;
  logic ro_q = 1'b0, busy_q = 1'b0, v_q = 1'b0, ro_tq = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // counter model + scoreboard monitor
  always @(negedge clk) begin
    cyc++;
    if (busy && !busy_q) begin
      start_cyc = cyc;
      mcount    = 0;
    end
    if (ro_en && !ro_q) begin
      chk("measure_pair_distinct", {31'd0, cha0 != cha1}, 1);
      if (mcount < 8) begin
        pair_log[mcount] = {cha0, cha1};
        puf_drv = pat[mcount];
        if (tie[mcount]) begin a_drv = 4'd7; b_drv = 4'd7; end
        else             begin a_drv = 4'd9; b_drv = 4'd5; end
      end
      mcount++;
    end
    if (resp_valid && !v_q) begin
      vrises++;
      chk("latency", cyc - start_cyc, 560);
    end
    if (resp_valid && resp_ready) begin
      if (expq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_valid: got response %0h with no expectation", response);
      end else begin
        e = expq.pop_front();
        chk("response", response, e[15:8]);
        chk("unstable", unstable, e[7:0]);
      end
      hs++;
    end
    // pulse widths on the short-window instance
    if (ro_t) hicnt++;
    if (ro_t && !ro_tq) begin
      chk("clr_width", lowcnt, 2);
      lowcnt = 0;
    end
    if (!ro_t && ro_tq) begin
      chk("window_width", hicnt, 10);
      hicnt = 0;
      wins++;
    end
    if (busy_t && !crn_t) lowcnt++;
    if (valid_t && ready_t) hs_t++;
    ro_q = ro_en; busy_q = busy; v_q = resp_valid; ro_tq = ro_t;
  end

  task automatic pulse(input logic [7:0] s);
    seed = s; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_hs(input int n);
    int h0;
    h0 = hs;
    for (int i = 0; i < n && hs == h0; i++) begin @(posedge clk); #1; end
    chk("handshake_seen", {31'd0, hs != h0}, 1);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; start_t = 1'b0; seed = 8'h00; resp_ready = 1'b1;
    puf_t = 1'b0; a_t = 4'd1; b_t = 4'd2; ready_t = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("rst_cha0", cha0, 0);
    chk("rst_cha1", cha1, 0);
    chk("rst_cnt_rst_n", cnt_rst_n, 0);
    chk("rst_ro_en", ro_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", resp_valid, 0);
    chk("rst_response", response, 0);
    chk("rst_unstable", unstable, 0);
    @(posedge clk); #1 reset = 1'b1;

    // reset in the middle of the first window
    pulse(8'hC8);
    repeat (28) @(posedge clk);
    #2 chk("ro_en_before_reset", ro_en, 1);
    reset = 1'b0;
    #1;
    chk("mid_rst_ro_en", ro_en, 0);
    chk("mid_rst_cnt_rst_n", cnt_rst_n, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", resp_valid, 0);
    @(posedge clk); #1 reset = 1'b1;
    repeat (600) @(posedge clk); #1;
    chk("no_valid_after_reset", vrises, 0);
    chk("idle_after_reset", busy, 0);

    // default run: even bits 1, no ties
    pat = 8'h55; tie = 8'h00;
    expq.push_back(16'h5500);
    pulse(8'hC8);
    wait_hs(700);
    chk("pair_bit0", pair_log[0], 8'hC8);
    chk("pair_bit1", pair_log[1], 8'hDB);

    // seed collision
    pat = 8'h00;
    expq.push_back(16'h0000);
    pulse(8'h33);
    wait_hs(700);
    chk("coll_pair_bit0", pair_log[0], 8'h34);
    chk("coll_pair_bit1", pair_log[1], 8'h47);

    // tie on bit 2 only
    pat = 8'hF0; tie = 8'h04;
    expq.push_back(16'hF004);
    pulse(8'hC8);
    wait_hs(700);
    tie = 8'h00;

    // backpressure, ignored starts
    resp_ready = 1'b0; pat = 8'h3C;
    expq.push_back(16'h3C00);
    pulse(8'hA5);
    for (int i = 0; i < 700 && !resp_valid; i++) begin @(posedge clk); #1; end
    chk("bp_valid_seen", resp_valid, 1);
    for (int i = 0; i < 20; i++) begin
      chk("bp_hold", {resp_valid, response, unstable}, {1'b1, 8'h3C, 8'h00});
      if (i == 5) begin seed = 8'hFF; start = 1'b1; end
      else start = 1'b0;
      @(posedge clk); #1;
    end
    resp_ready = 1'b1; start = 1'b1; seed = 8'h11;
    @(posedge clk); #1 start = 1'b0;
    chk("bp_valid_drop", resp_valid, 0);
    chk("bp_idle", busy, 0);
    chk("bp_response_kept", response, 8'h3C);
    repeat (3) @(posedge clk); #1;
    chk("bp_start_ignored", busy, 0);

    // pulse widths, short window instance
    start_t = 1'b1;
    @(posedge clk); #1 start_t = 1'b0;
    for (int i = 0; i < 300 && hs_t == 0; i++) begin @(posedge clk); #1; end
    chk("timing_done", hs_t, 1);
    chk("timing_windows", wins, 8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
